// File: rtl/cve2_pkg.sv
// -----------------------------------------------------------------------------
// cve2_pkg
// Shared types and helpers for the CVE2 OBI-to-SRAM data-port adapter.
//   obi_sram_state_e : response FSM state of cve2_obi_sram_adapter
//   be_to_mask()     : expands a 4-bit byte enable into a 32-bit bit mask
// -----------------------------------------------------------------------------
package cve2_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESP_RD  = 2'd1,
        RESP_WR  = 2'd2,
        RESP_ERR = 2'd3
    } obi_sram_state_e;

    // Each byte-enable bit covers eight data bits of the SRAM word.
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[i*8 +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/cve2_obi_sram_adapter.sv
// -----------------------------------------------------------------------------
// cve2_obi_sram_adapter
// Bridges the CVE2 core OBI data port onto a single-port SRAM with a one-cycle
// read latency. Requests are granted when the shared SRAM port is available,
// or immediately when the request is bad (no byte enables, or outside the
// window when range checking is built in). Every accepted request produces
// exactly one response one cycle later; one transaction per cycle is sustained.
//
// Build option:
//   CVE2_OBI_SRAM_RANGE_CHECK_EN  defined   -> addresses outside
//                                              [MemBase, MemBase + 4*MemDepth)
//                                              get an error response.
//                                 undefined -> no window check; addresses alias
//                                              modulo the SRAM size.
//
// Parameters:
//   MemBase   byte base address of the SRAM window (word aligned)
//   MemDepth  SRAM depth in 32-bit words (power of two, >= 2)
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   data_req_i/we_i/be_i/addr_i/wdata_i OBI request from the core
//   data_gnt_o                         request accepted this cycle
//   data_rvalid_o/rdata_o/err_o        OBI response
//   sram_req_o/we_o/addr_o             SRAM strobe, write enable, word address
//   sram_wmask_o/wdata_o               SRAM bit write mask, write data
//   sram_gnt_i                         SRAM port available this cycle
//   sram_rdata_i                       SRAM read data (one cycle after read)
// -----------------------------------------------------------------------------
module cve2_obi_sram_adapter
    import cve2_pkg::*;
#(
    parameter logic [31:0] MemBase  = 32'h0000_0000,
    parameter int unsigned MemDepth = 4096
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,

    input  logic                        data_req_i,
    input  logic                        data_we_i,
    input  logic [3:0]                  data_be_i,
    input  logic [31:0]                 data_addr_i,
    input  logic [31:0]                 data_wdata_i,
    output logic                        data_gnt_o,
    output logic                        data_rvalid_o,
    output logic [31:0]                 data_rdata_o,
    output logic                        data_err_o,

    output logic                        sram_req_o,
    output logic                        sram_we_o,
    output logic [$clog2(MemDepth)-1:0] sram_addr_o,
    output logic [31:0]                 sram_wmask_o,
    output logic [31:0]                 sram_wdata_o,
    input  logic                        sram_gnt_i,
    input  logic [31:0]                 sram_rdata_i
);

    localparam int unsigned AddrW = $clog2(MemDepth);

    // Elaboration-time sanity checks on the configuration.
    if (MemDepth < 2 || (MemDepth & (MemDepth - 1)) != 0) begin : g_depth_check
        $error("MemDepth must be a power of two and at least 2");
    end
    if (MemBase[1:0] != 2'b00) begin : g_base_check
        $error("MemBase must be word aligned");
    end

    obi_sram_state_e state_q, state_d;

    logic bad;
    logic accept;
    logic in_window;

`ifdef CVE2_OBI_SRAM_RANGE_CHECK_EN
    // One extra bit so a window ending at 4 GiB does not wrap to zero.
    localparam logic [32:0] MemEnd = {1'b0, MemBase} + 33'(4 * MemDepth);
    assign in_window = (data_addr_i >= MemBase) && ({1'b0, data_addr_i} < MemEnd);
`else
    assign in_window = 1'b1;
`endif

    // Word-offset bits and the bits above the SRAM index only matter to the
    // window check; without it the address simply aliases.
    logic unused_addr;
    assign unused_addr = ^{data_addr_i[31:AddrW+2], data_addr_i[1:0]};

    assign bad    = (data_be_i == 4'h0) || !in_window;
    // Bad requests are answered locally, so they never wait on the SRAM port.
    assign accept = data_req_i && (sram_gnt_i || bad);

    assign data_gnt_o   = accept;
    assign sram_req_o   = data_req_i && sram_gnt_i && !bad;
    assign sram_we_o    = data_we_i;
    assign sram_addr_o  = data_addr_i[AddrW+1:2];
    assign sram_wmask_o = be_to_mask(data_be_i);
    assign sram_wdata_o = data_wdata_i;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create simulation/synthesis races.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The response state is re-decided every cycle, which is what allows a new
    // accept in the same cycle the previous response is presented.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // skipped an assignment would infer a latch.
        state_d       = IDLE;
        data_rvalid_o = (state_q != IDLE);
        data_rdata_o  = 32'h0;
        data_err_o    = 1'b0;

        if (accept) begin
            if (bad) begin
                state_d = RESP_ERR;
            end else if (data_we_i) begin
                state_d = RESP_WR;
            end else begin
                state_d = RESP_RD;
            end
        end

        unique case (state_q)
            RESP_RD:  data_rdata_o = sram_rdata_i;
            RESP_ERR: data_err_o   = 1'b1;
            default:  ;
        endcase
    end

    a_rvalid_known : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown(data_rvalid_o));

    a_sram_req_good : assert property (@(posedge clk_i) disable iff (!rst_ni)
        sram_req_o |-> !bad);

endmodule
